pll_clken_gen: RTL and testbench
================================

Name: pll_clken_gen

Overview:
Multi-channel fractional clock-enable generator; successor to the fixed two-output PLL wrapper.
- Runs on a single PLL output clock.
- Qualifies the raw PLL locked signal with a synchroniser and settle counter.
- Derives NUM_CH programmable-rate clock enables with phase accumulators instead of extra PLL outputs.
- Sequences the core reset, plus sticky loss-of-lock reporting and a global phase realignment.

Parameters:
NUM_CH, 4, number of clock-enable channels (1..16)
ACC_W, 24, phase accumulator / increment width; f_en = f_refclk * inc / 2^ACC_W
LOCK_CYCLES, 1024, cycles locked must stay high before release (>=1)
SYNC_STAGES, 2, synchroniser depth on pll_locked (>=2)

Ports:
refclk  in  1  PLL output clock; all logic on its rising edge
rst_n  in  1  reset; synchronous, active-low
pll_locked  in  1  raw PLL locked, asynchronous to refclk
cfg_we  in  1  increment write strobe
cfg_ch  in  clog2(NUM_CH) (min 1)  channel select for cfg_we
cfg_inc  in  ACC_W  increment value written
ch_en  in  NUM_CH  per-channel run enable
resync  in  1  pulse: zero all accumulators simultaneously
lost_clr  in  1  pulse: clear lock_lost
clken  out  NUM_CH  single-cycle enable pulses, registered
sys_rst_n  out  1  core reset; high only in RUN, registered
lock_ok  out  1  high in RUN
lock_lost  out  1  sticky: lock dropped while in RUN
stats  out  NUM_CH*16  per-channel pulse counts (optional feature)

Behaviour:
- Reset (rst_n=0 at an edge):
  - State WAIT_LOCK.
  - All accumulators, increments, settle counter and sync flops are 0.
  - All outputs are 0.
- Sync: locked_s is pll_locked through SYNC_STAGES flops.
- FSM:
  - WAIT_LOCK: locked_s=1 -> SETTLE, counter=0.
  - SETTLE: counter++ each cycle.
    - locked_s=0 -> WAIT_LOCK.
    - counter==LOCK_CYCLES-1 with locked_s=1 -> RUN.
  - RUN: locked_s=0 -> LOST, set lock_lost.
  - LOST: exactly one cycle, then WAIT_LOCK unconditionally.
- Release timing: sys_rst_n and lock_ok are flops set on the edge that enters RUN and cleared on the edge that leaves it. A clean lock edge gives sys_rst_n high SYNC_STAGES+1+LOCK_CYCLES edges later.
- Channel k:
  - {carry,acc_k} <= acc_k + inc_k each edge while RUN and ch_en[k].
  - clken[k] <= carry (width 1, one-cycle latency).
  - Outside RUN, or ch_en[k]=0: acc_k <= 0 and clken[k] <= 0.
  - inc_k=0: never fires. inc_k=2^ACC_W-1: fires every cycle after the first.
- cfg_we: inc[cfg_ch] <= cfg_inc; acc_k is not disturbed; the new rate applies from the next addition. Accepted in every state. cfg_ch >= NUM_CH is ignored.
- resync in RUN: all acc <= 0 and clken <= 0 on that edge; the addition is suppressed. No effect outside RUN.
- Same-cycle events:
  - resync with cfg_we: both apply.
  - lost_clr with a new loss: set wins.
  - ch_en falling mid-period: acc zeroed; the pulse is lost, not deferred.
- rst_n low mid-RUN: immediate return to reset values; sys_rst_n drops on that edge.

Optional Feature:
PLL_CLKEN_STATS_EN
- Defined: per-channel 16-bit saturating counter, +1 per clken pulse, cleared on reset, resync, or outside RUN. Driven on stats[16k+15:16k].
- Undefined: no counters; stats tied to 0; port kept for a stable interface.

Decomposition:
- Package pll_clken_pkg:
  - FSM state enum (WAIT_LOCK, SETTLE, RUN, LOST, 2-bit).
  - STATS_W=16 constant.
  - A clog2-with-minimum-1 function.
- Sub-module pll_clken_acc holds one channel: increment register, accumulator, carry flop and optional stats counter. It is instantiated NUM_CH times by a generate loop. The FSM and synchroniser stay in the top level.

Test Plan:
1. LOCK_CYCLES=16, SYNC_STAGES=2, pll_locked 0->1 -> sys_rst_n and lock_ok rise exactly 19 edges later; clken all 0 before that.
2. pll_locked pulses high for 10 cycles during SETTLE -> back to WAIT_LOCK, sys_rst_n never rises; the next full lock releases 19 edges after its edge.
3. ACC_W=16, inc0=0x4000, ch_en=1 in RUN -> first clken[0] 4 edges after RUN entry, then period 4. inc1=0x6000 -> exactly 3 pulses per 8 cycles, 0 drift over 800 cycles (300 pulses).
4. pll_locked drops in RUN -> sys_rst_n/lock_ok low, clken 0, lock_lost=1. lost_clr in the same cycle as a second loss -> lock_lost stays 1. lost_clr alone -> 0.
5. Channels 0,1 at inc=0x4000 with different phases, resync pulse -> both fire together 4 edges later. Simultaneous cfg_we to ch2 takes effect with acc2 starting from 0.
6. With PLL_CLKEN_STATS_EN defined, inc=0xFFFF for 70000 RUN cycles -> stats[15:0]=0xFFFF (saturated). Without the macro -> stats=0.

Source files
------------

// File: rtl/pll_clken_pkg.sv
// Shared types and helpers for the PLL clock-enable generator.
package pll_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } pll_state_t;

    localparam int STATS_W = 16;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_clken_acc.sv
// One clock-enable channel: increment register, phase accumulator whose
// carry is the registered enable pulse, and an optional pulse counter
// (present only when PLL_CLKEN_STATS_EN is defined, otherwise stats is 0).
module pll_clken_acc
    import pll_clken_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               ch_en,
    input  logic               resync,
    input  logic               inc_we,
    input  logic [ACC_W-1:0]   inc_val,
    output logic               clken,
    output logic [STATS_W-1:0] stats
);

    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;
    logic             active;

    // A resync edge zeroes the phase instead of advancing it.
    assign active = run && ch_en && !resync;
    assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

    // Increment register; writes are taken in every state.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            inc_q <= '0;
        end else if (inc_we) begin
            inc_q <= inc_val;
        end
    end

    // Phase accumulator; the addition carry becomes the enable pulse.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            acc_q <= '0;
            clken <= 1'b0;
        end else if (active) begin
            {clken, acc_q} <= sum;
        end else begin
            acc_q <= '0;
            clken <= 1'b0;
        end
    end

`ifdef PLL_CLKEN_STATS_EN
    logic [STATS_W-1:0] cnt_q;

    // Saturating count of emitted pulses, restarted by resync or leaving RUN.
    always_ff @(posedge refclk) begin
        if (!rst_n || !run || resync) begin
            cnt_q <= '0;
        end else if (clken && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STATS_W'(1);
        end
    end

    assign stats = cnt_q;
`else
    assign stats = '0;
`endif

endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator: qualifies the PLL lock,
// sequences the core reset and drives NUM_CH accumulator channels.
// Optional per-channel pulse counters are enabled with PLL_CLKEN_STATS_EN.
module pll_clken_gen
    import pll_clken_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int ACC_W       = 24,
    parameter  int LOCK_CYCLES = 1024,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = clog2_min1(NUM_CH)
) (
    input  logic                      refclk,
    input  logic                      rst_n,
    input  logic                      pll_locked,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [ACC_W-1:0]          cfg_inc,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      resync,
    input  logic                      lost_clr,
    output logic [NUM_CH-1:0]         clken,
    output logic                      sys_rst_n,
    output logic                      lock_ok,
    output logic                      lock_lost,
    output logic [NUM_CH*STATS_W-1:0] stats
);

    localparam int CNT_W = clog2_min1(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    pll_state_t             state_q;
    pll_state_t             state_nx;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   run_q;
    logic                   lost_q;
    logic                   lost_nx;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous PLL lock flag into the refclk domain.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Lock sequencer state, settle counter and registered status outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            run_q   <= (state_nx == RUN);
            lost_q  <= lost_nx;
        end
    end

    // Next-state logic; a new loss overrides a simultaneous clear.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        lost_nx  = lost_q;
        if (lost_clr) begin
            lost_nx = 1'b0;
        end
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = SETTLE;
                    cnt_nx   = '0;
                end
            end
            SETTLE: begin
                cnt_nx = cnt_q + CNT_W'(1);
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = LOST;
                    lost_nx  = 1'b1;
                end
            end
            LOST: begin
                state_nx = WAIT_LOCK;
            end
            default: begin
                state_nx = WAIT_LOCK;
            end
        endcase
    end

    assign sys_rst_n = run_q;
    assign lock_ok   = run_q;
    assign lock_lost = lost_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pll_clken_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .run     (run_q),
            .ch_en   (ch_en[k]),
            .resync  (resync),
            .inc_we  (cfg_we && (cfg_ch == CH_W'(k))),
            .inc_val (cfg_inc),
            .clken   (clken[k]),
            .stats   (stats[k*STATS_W +: STATS_W])
        );
    end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Self-checking bench for pll_clken_gen (NUM_CH=4, ACC_W=16, LOCK_CYCLES=16).
// Expected pulse vectors and latencies go into queues as stimulus is driven
// and are popped as the DUT responds. Define PLL_CLKEN_STATS_EN for counters.
module tb_pll_clken_gen;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 16;
    localparam int LOCK_C = 16;
    localparam int SYNC_S = 2;
    localparam int REL    = SYNC_S + 1 + LOCK_C;

    logic                 refclk = 1'b0;
    logic                 rst_n;
    logic                 pll_locked;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [ACC_W-1:0]     cfg_inc;
    logic [NUM_CH-1:0]    ch_en;
    logic                 resync;
    logic                 lost_clr;
    logic [NUM_CH-1:0]    clken;
    logic                 sys_rst_n;
    logic                 lock_ok;
    logic                 lock_lost;
    logic [NUM_CH*16-1:0] stats;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt[NUM_CH];

    logic [NUM_CH-1:0] exp_vec_q[$];
    int                exp_lat_q[$];

    pll_clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_C),
        .SYNC_STAGES (SYNC_S)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .ch_en      (ch_en),
        .resync     (resync),
        .lost_clr   (lost_clr),
        .clken      (clken),
        .sys_rst_n  (sys_rst_n),
        .lock_ok    (lock_ok),
        .lock_lost  (lock_lost),
        .stats      (stats)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Whether addition k (k>=1, from acc=0) of increment inc overflows.
    function automatic logic fires(input int k, input logic [ACC_W-1:0] inc);
        longint a;
        longint b;
        a = (longint'(k) * longint'(inc)) >> ACC_W;
        b = (longint'(k - 1) * longint'(inc)) >> ACC_W;
        return a != b;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        ch_en      = '0;
        resync     = 1'b0;
        lost_clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_inc(input logic [1:0] ch, input logic [ACC_W-1:0] val);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_inc = val;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Raise pll_locked and measure edges until the core reset releases.
    task automatic lock_up();
        int  n;
        int  exp_n;
        bit  gated_ok;
        exp_lat_q.push_back(REL);
        pll_locked = 1'b1;
        n          = 0;
        gated_ok   = 1'b1;
        while (sys_rst_n !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (sys_rst_n !== 1'b1 && clken !== '0) gated_ok = 1'b0;
        end
        exp_n = exp_lat_q.pop_front();
        tests_run++;
        if (n != exp_n) begin
            tests_failed++;
            $display("[TB] FAIL lock_latency: got %0d edges, expected %0d", n, exp_n);
        end
        tests_run++;
        if (!gated_ok) begin
            tests_failed++;
            $display("[TB] FAIL clken_before_run: clken nonzero before release");
        end
        tests_run++;
        if (lock_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lock_ok_rise: got %b, expected 1", lock_ok);
        end
    endtask

    // Pop one expected clken vector per edge and compare.
    task automatic check_vectors(input int n);
        logic [NUM_CH-1:0] exp;
        for (int i = 0; i < NUM_CH; i++) pulse_cnt[i] = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            exp = exp_vec_q.pop_front();
            for (int i = 0; i < NUM_CH; i++) pulse_cnt[i] += int'(clken[i]);
            tests_run++;
            if (clken !== exp) begin
                tests_failed++;
                $display("[TB] FAIL clken_vec[%0d]: got %b, expected %b", k, clken, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({sys_rst_n, lock_ok, lock_lost} !== 3'b000 || clken !== '0 || stats !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got rst=%b ok=%b lost=%b clken=%b stats=%h, expected all 0",
                     sys_rst_n, lock_ok, lock_lost, clken, stats);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_release();
        do_reset();
        write_inc(2'd0, 16'hFFFF);
        ch_en = 4'b1111;
        lock_up();
    endtask

    task automatic test_settle_abort();
        bit stayed_low;
        do_reset();
        pll_locked = 1'b1;
        repeat (10) tick();
        pll_locked = 1'b0;
        stayed_low = 1'b1;
        repeat (30) begin
            tick();
            if (sys_rst_n !== 1'b0) stayed_low = 1'b0;
        end
        tests_run++;
        if (!stayed_low) begin
            tests_failed++;
            $display("[TB] FAIL settle_abort: sys_rst_n rose, expected it to stay 0");
        end
        lock_up();
    endtask

    task automatic test_rate();
        do_reset();
        write_inc(2'd0, 16'h4000);
        write_inc(2'd1, 16'h6000);
        ch_en = 4'b0011;
        for (int k = 1; k <= 800; k++)
            exp_vec_q.push_back({2'b00, fires(k, 16'h6000), fires(k, 16'h4000)});
        lock_up();
        check_vectors(800);
        tests_run++;
        if (pulse_cnt[0] != 200) begin
            tests_failed++;
            $display("[TB] FAIL rate_ch0_count: got %0d, expected 200", pulse_cnt[0]);
        end
        tests_run++;
        if (pulse_cnt[1] != 300) begin
            tests_failed++;
            $display("[TB] FAIL rate_ch1_count: got %0d, expected 300", pulse_cnt[1]);
        end
    endtask

    task automatic test_loss();
        int n;
        do_reset();
        write_inc(2'd0, 16'hFFFF);
        ch_en = 4'b0001;
        lock_up();
        repeat (4) tick();
        pll_locked = 1'b0;
        n = 0;
        while (lock_ok !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != SYNC_S + 1) begin
            tests_failed++;
            $display("[TB] FAIL loss_latency: got %0d edges, expected %0d", n, SYNC_S + 1);
        end
        tests_run++;
        if (sys_rst_n !== 1'b0 || lock_lost !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL loss_flags: got rst=%b lost=%b, expected rst=0 lost=1", sys_rst_n, lock_lost);
        end
        tick();
        tick();
        tests_run++;
        if (clken !== '0) begin
            tests_failed++;
            $display("[TB] FAIL loss_clken: got %b, expected 0000", clken);
        end
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        tests_run++;
        if (lock_lost !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lost_clr_alone: got %b, expected 0", lock_lost);
        end
        lock_up();
        pll_locked = 1'b0;
        tick();
        tick();
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        tests_run++;
        if (lock_ok !== 1'b0 || lock_lost !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL set_beats_clr: got ok=%b lost=%b, expected ok=0 lost=1", lock_ok, lock_lost);
        end
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        tests_run++;
        if (lock_lost !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lost_clr_second: got %b, expected 0", lock_lost);
        end
    endtask

    task automatic test_resync();
        do_reset();
        write_inc(2'd0, 16'h4000);
        write_inc(2'd1, 16'h4000);
        write_inc(2'd2, 16'h3000);
        ch_en = 4'b0101;
        lock_up();
        tick();
        ch_en = 4'b0111;
        repeat (5) tick();
        resync  = 1'b1;
        cfg_we  = 1'b1;
        cfg_ch  = 2'd2;
        cfg_inc = 16'h4000;
        tick();
        resync  = 1'b0;
        cfg_we  = 1'b0;
        tests_run++;
        if (clken !== '0) begin
            tests_failed++;
            $display("[TB] FAIL resync_edge: got %b, expected 0000", clken);
        end
        for (int k = 1; k <= 12; k++)
            exp_vec_q.push_back((k % 4 == 0) ? 4'b0111 : 4'b0000);
        check_vectors(12);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        write_inc(2'd0, 16'hFFFF);
        ch_en = 4'b0001;
        lock_up();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({sys_rst_n, lock_ok, lock_lost} !== 3'b000 || clken !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_run_reset: got rst=%b ok=%b lost=%b clken=%b, expected all 0",
                     sys_rst_n, lock_ok, lock_lost, clken);
        end
        rst_n = 1'b1;
        ch_en = 4'b1111;
        lock_up();
        for (int k = 1; k <= 20; k++) exp_vec_q.push_back(4'b0000);
        check_vectors(20);
    endtask

    task automatic test_stats();
        do_reset();
        write_inc(2'd0, 16'hFFFF);
        ch_en = 4'b0001;
        lock_up();
`ifdef PLL_CLKEN_STATS_EN
        repeat (70000) tick();
        tests_run++;
        if (stats[15:0] !== 16'hFFFF || stats[63:16] !== '0) begin
            tests_failed++;
            $display("[TB] FAIL stats_saturate: got %h, expected 000000000000ffff", stats);
        end
`else
        repeat (20) tick();
        tests_run++;
        if (stats !== '0) begin
            tests_failed++;
            $display("[TB] FAIL stats_tied: got %h, expected 0", stats);
        end
`endif
    endtask

    initial begin
        do_reset();
        test_reset();
        test_lock_release();
        test_settle_abort();
        test_rate();
        test_loss();
        test_resync();
        test_reset_mid_run();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
